gated_edge_counter: RTL and testbench

//  Measures the frequency of an asynchronous input by counting its rising edges over a gate

---
 rtl/gated_edge_counter_pkg.sv | 10 +
 rtl/gated_edge_counter_sync_edge_detect.sv | 27 ++
 rtl/gated_edge_counter.sv | 113 +++++++++++
 tb/tb_gated_edge_counter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gated_edge_counter_pkg.sv
// rtl/gated_edge_counter_pkg.sv - shared state encoding for the gated edge counter
package gated_edge_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } state_t;

endpackage

// File: rtl/gated_edge_counter_sync_edge_detect.sv
// rtl/gated_edge_counter_sync_edge_detect.sv - 2-flop synchroniser with rising-edge pulse
module gated_edge_counter_sync_edge_detect (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_s2_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_s2_d <= 1'b0;
      end else begin
         r_s1   <= i_async;
         r_s2   <= r_s1;
         r_s2_d <= r_s2;
      end
   end

   assign o_rise = r_s2 & ~r_s2_d;

endmodule

// File: rtl/gated_edge_counter.sv
// rtl/gated_edge_counter.sv - counts sig_in rising edges over a window of gate strobes
module gated_edge_counter
   import gated_edge_counter_pkg::*;
#(
   parameter int COUNT_WIDTH = 24,
   parameter int GATE_WIDTH  = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_enable,
   input  logic                   i_gate_pulse,
   input  logic [GATE_WIDTH-1:0]  i_gate_len,
   input  logic                   i_sig_in,
   output logic [COUNT_WIDTH-1:0] o_count,
   output logic                   o_count_valid,
   output logic                   o_overflow,
   output logic                   o_busy
);

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_edge;
   logic [COUNT_WIDTH-1:0] r_acc;
   logic                   r_sat;
   logic [GATE_WIDTH-1:0]  r_gcnt;
   logic [GATE_WIDTH-1:0]  r_len;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   r_overflow;
   logic                   r_count_valid;
   logic [COUNT_WIDTH:0]   w_sum;
   logic                   w_carry;
   logic [COUNT_WIDTH-1:0] w_acc_next;
   logic [GATE_WIDTH-1:0]  w_len_eff;
   logic                   w_close;
   logic                   w_start;

   gated_edge_counter_sync_edge_detect u_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_sig_in),
      .o_rise  (w_edge)
   );

   // A carry out of the accumulator means an edge could not be counted.
   assign w_sum      = {1'b0, r_acc} + {{COUNT_WIDTH{1'b0}}, w_edge};
   assign w_carry    = w_sum[COUNT_WIDTH];
   assign w_acc_next = w_carry ? {COUNT_WIDTH{1'b1}} : w_sum[COUNT_WIDTH-1:0];
   assign w_len_eff  = (i_gate_len == '0) ? GATE_WIDTH'(1) : i_gate_len;

   assign w_close = (r_state == ST_MEASURE) && i_gate_pulse
                    && (r_gcnt == r_len - GATE_WIDTH'(1));
   assign w_start = i_enable && ((r_state == ST_ARM && i_gate_pulse) || w_close);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (i_enable) w_next = ST_ARM;
         ST_ARM: begin
            if (!i_enable)        w_next = ST_IDLE;
            else if (i_gate_pulse) w_next = ST_MEASURE;
         end
         ST_MEASURE: if (!i_enable) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state != ST_IDLE);
   end

   // The closing strobe doubles as the next window's arming strobe when enabled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc         <= '0;
         r_sat         <= 1'b0;
         r_gcnt        <= '0;
         r_len         <= '0;
         r_count       <= '0;
         r_overflow    <= 1'b0;
         r_count_valid <= 1'b0;
      end else begin
         r_count_valid <= 1'b0;
         if (w_close) begin
            r_count       <= w_acc_next;
            r_overflow    <= r_sat | w_carry;
            r_count_valid <= 1'b1;
         end
         if (w_start) begin
            r_acc  <= '0;
            r_sat  <= 1'b0;
            r_gcnt <= '0;
            r_len  <= w_len_eff;
         end else if (r_state == ST_MEASURE) begin
            r_acc <= w_acc_next;
            r_sat <= r_sat | w_carry;
            if (i_gate_pulse) r_gcnt <= r_gcnt + GATE_WIDTH'(1);
         end
      end
   end

   assign o_count       = r_count;
   assign o_overflow    = r_overflow;
   assign o_count_valid = r_count_valid;

endmodule

// File: tb/tb_gated_edge_counter.sv
// tb/tb_gated_edge_counter.sv - directed self-checking bench for gated_edge_counter
module tb_gated_edge_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        gate_pulse;
   logic [15:0] gate_len;
   logic        sig_in;
   logic [23:0] count;
   logic        count_valid;
   logic        overflow;
   logic        busy;
   logic [3:0]  count4;
   logic        count_valid4;
   logic        overflow4;
   logic        busy4;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int g_per    = 10;
   int g_ph     = 0;
   int s_per    = 4;
   int s_ph     = 0;

   logic [23:0] q_cnt[$];
   logic        q_ovf[$];
   int          q_cyc[$];
   logic [3:0]  q4_cnt[$];
   logic        q4_ovf[$];

   always #5 clk = ~clk;

   gated_edge_counter dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_enable      (enable),
      .i_gate_pulse  (gate_pulse),
      .i_gate_len    (gate_len),
      .i_sig_in      (sig_in),
      .o_count       (count),
      .o_count_valid (count_valid),
      .o_overflow    (overflow),
      .o_busy        (busy)
   );

   gated_edge_counter #(.COUNT_WIDTH(4), .GATE_WIDTH(16)) dut4 (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_enable      (enable),
      .i_gate_pulse  (gate_pulse),
      .i_gate_len    (gate_len),
      .i_sig_in      (sig_in),
      .o_count       (count4),
      .o_count_valid (count_valid4),
      .o_overflow    (overflow4),
      .o_busy        (busy4)
   );

   always @(negedge clk) begin
      if (count_valid) begin
         q_cnt.push_back(count);
         q_ovf.push_back(overflow);
         q_cyc.push_back(cyc);
      end
      if (count_valid4) begin
         q4_cnt.push_back(count4);
         q4_ovf.push_back(overflow4);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      gate_pulse = (g_ph == 0);
      sig_in     = (s_ph < s_per / 2);
      @(posedge clk);
      #1;
      g_ph = (g_ph + 1) % g_per;
      s_ph = (s_ph + 1) % s_per;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_q();
      q_cnt.delete(); q_ovf.delete(); q_cyc.delete();
      q4_cnt.delete(); q4_ovf.delete();
   endtask

   task automatic wait_pulses(input string tag, input int n, input int budget);
      int k = 0;
      while (q_cnt.size() < n && k < budget) begin
         tick();
         k++;
      end
      check(tag, 32'(q_cnt.size() >= n), 32'd1);
   endtask

   task automatic configure(input logic [15:0] len, input int sp);
      enable = 1'b0;
      run(5);
      gate_len = len;
      s_per    = sp;
      s_ph     = 0;
      clear_q();
      enable   = 1'b1;
   endtask

   initial begin
      int t0;
      int el;
      rst        = 1'b1;
      enable     = 1'b0;
      gate_pulse = 1'b0;
      gate_len   = 16'd4;
      sig_in     = 1'b0;
      run(3);
      check("rst_count",  32'(count), 32'd0);
      check("rst_valid",  32'(count_valid), 32'd0);
      check("rst_ovf",    32'(overflow), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_busy4",  32'(busy4), 32'd0);
      rst = 1'b0;
      run(2);

      // Five back-to-back 40-cycle windows of 10 edges each.
      configure(16'd4, 4);
      run(3);
      check("t1_busy", 32'(busy), 32'd1);
      wait_pulses("t1_timeout", 5, 400);
      for (int i = 0; i < q_cnt.size(); i++) begin
         check($sformatf("t1_count%0d", i), 32'(q_cnt[i]), 32'd10);
         check($sformatf("t1_ovf%0d", i), 32'(q_ovf[i]), 32'd0);
         if (i > 0) check($sformatf("t1_gap%0d", i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd40);
      end
      check("t2_pulses", 32'(q_cnt.size()), 32'd5);

      // gate_len=0 behaves as one strobe per window.
      configure(16'd0, 5);
      wait_pulses("t4_timeout", 3, 60);
      for (int i = 0; i < q_cnt.size(); i++) begin
         check($sformatf("t4_count%0d", i), 32'(q_cnt[i]), 32'd2);
         if (i > 0) check($sformatf("t4_gap%0d", i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd10);
      end

      // 40 edges in an 80-cycle window; the 4-bit instance saturates.
      configure(16'd8, 2);
      wait_pulses("t3_timeout", 1, 120);
      if (q_cnt.size() > 0) begin
         check("t3_count24", 32'(q_cnt[0]), 32'd40);
         check("t3_ovf24",   32'(q_ovf[0]), 32'd0);
      end
      check("t3_pulses4", 32'(q4_cnt.size()), 32'd1);
      if (q4_cnt.size() > 0) begin
         check("t3_count4", 32'(q4_cnt[0]), 32'd15);
         check("t3_ovf4",   32'(q4_ovf[0]), 32'd1);
      end

      // Abort 15 cycles into a window.
      configure(16'd4, 4);
      wait_pulses("t5_timeout", 1, 70);
      if (q_cnt.size() > 0) check("t5_first", 32'(q_cnt[0]), 32'd10);
      run(15);
      enable = 1'b0;
      clear_q();
      run(2);
      check("t5_busy", 32'(busy), 32'd0);
      run(60);
      check("t5_no_valid", 32'(q_cnt.size()), 32'd0);
      check("t5_hold_count", 32'(count), 32'd10);
      check("t5_hold_ovf", 32'(overflow), 32'd0);

      // Reset mid-window, then a full re-arm before the next result.
      enable = 1'b1;
      wait_pulses("t6_timeout_a", 1, 70);
      run(15);
      rst = 1'b1;
      run(1);
      check("t6_count", 32'(count), 32'd0);
      check("t6_valid", 32'(count_valid), 32'd0);
      check("t6_ovf",   32'(overflow), 32'd0);
      check("t6_busy",  32'(busy), 32'd0);
      clear_q();
      rst = 1'b0;
      run(1);
      t0 = cyc;
      wait_pulses("t6_timeout_b", 1, 80);
      if (q_cnt.size() > 0) begin
         el = q_cyc[0] - t0;
         check("t6_latency_ok", 32'(el >= 41 && el <= 51), 32'd1);
         check("t6_count_after", 32'(q_cnt[0]), 32'd10);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
